threshold_fifo_queue: RTL and testbench
=======================================

# threshold_fifo_queue

Parametrised synchronous FIFO for request buffering between pipeline stages, successor to the fixed power-of-two queue. It supports any depth ≥ 2, a valid/ready write port, and a valid/ack read port. It also provides an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush and an overflow pulse. It is used wherever upstream logic needs early back-pressure (credit-style) rather than a bare full flag.

## Interface
- DATA_WIDTH, 64, entry width in bits
- DEPTH, 16, number of entries; any integer ≥ 2, power of two not required
- PTR_WIDTH, $clog2(DEPTH), read/write pointer width
- COUNT_WIDTH, $clog2(DEPTH+1), occupancy counter width
- ALMOST_FULL_THRESHOLD, DEPTH-2, almost_full_out asserted when count ≥ this value
- ALMOST_EMPTY_THRESHOLD, 2, almost_empty_out asserted when count ≤ this value

Reset is reset_in, asynchronous, active-high; the clock is clk_in.

- clk_in  input  1  clock
- reset_in  input  1  asynchronous active-high reset
- flush_in  input  1  synchronous clear of all contents
- request_in  input  DATA_WIDTH  write data
- request_valid_in  input  1  write request
- request_ready_out  output  1  queue can accept a write this cycle
- request_out  output  DATA_WIDTH  head entry; zero when request_valid_out=0
- request_valid_out  output  1  head entry valid
- issue_ack_in  input  1  consumer takes head entry
- count_out  output  COUNT_WIDTH  current occupancy
- is_empty_out  output  1  count == 0
- is_full_out  output  1  count == DEPTH
- almost_full_out  output  1  count ≥ ALMOST_FULL_THRESHOLD
- almost_empty_out  output  1  count ≤ ALMOST_EMPTY_THRESHOLD
- overflow_out  output  1  one-cycle pulse: write attempted while full

## Operation
- Storage: DEPTH × DATA_WIDTH flop array, not reset. Occupancy is tracked by the counter, not per-entry valid bits.
- push = request_valid_in & request_ready_out & ~flush_in. Data is written at write_ptr, and write_ptr advances.
- pop = issue_ack_in & request_valid_out & ~flush_in. read_ptr advances.
- issue_ack_in while request_valid_out=0 is ignored.
- Pointers wrap from DEPTH-1 to 0 by explicit compare, not natural overflow.
- count_next = count + push − pop. Push and pop in the same cycle leave the count unchanged.
- Status flags, count_out, request_ready_out and request_valid_out are registers loaded from count_next.
- request_ready_out = ~is_full_out. A write while full is refused even if a pop occurs in the same cycle; there is no full-bypass.
- request_out = storage[read_ptr] when request_valid_out=1, else 0. This is a mux from flops with no added register stage.
- flush_in has priority over push and pop. Next cycle: pointers = 0, count = 0, flags take their empty values. A write presented during flush is dropped, and overflow_out is not raised.
- overflow_out is registered: 1 in cycle N+1 iff cycle N had request_valid_in & is_full_out & ~flush_in. The request is not stored.
- Thresholds are evaluated on count_next with unsigned compares of COUNT_WIDTH width.

## Timing
- Reset values:
  - count_out = 0; read and write pointers = 0.
  - is_empty_out = 1, almost_empty_out = 1, request_ready_out = 1.
  - is_full_out, almost_full_out, request_valid_out, overflow_out = 0.
  - request_out = 0.
- Write-to-read latency is 1 cycle: a push in cycle N gives request_valid_out=1 with that data in cycle N+1.
- A pop in cycle N presents the next entry, or valid=0, in cycle N+1.
- Throughput is one push plus one pop per cycle in steady state.
- A full queue gives request_ready_out=0. A pop in cycle N re-asserts ready in cycle N+1.
- Reset mid-operation clears the block asynchronously. Contents are lost; the first push after reset is read first.

## Test plan
- Reset, then push 0x11..0x16 on consecutive cycles (DEPTH=16), then ack continuously -> data out in the same order; count_out rises to 6 then falls to 0; request_valid_out lags the first push by 1 cycle.
- Fill DEPTH=5 (non-power-of-2) with 5 pushes -> is_full_out=1, request_ready_out=0. Push again -> overflow_out pulses one cycle, count stays 5. Drain -> pointers wrap 4→0 with no data loss.
- Sustained simultaneous push and pop at count=3 for 20 cycles -> count_out constant at 3, data order preserved across wrap.
- DEPTH=16, AF=14, AE=2: step count 0→16→0 -> almost_empty_out=1 for count ≤ 2; almost_full_out=1 for count ≥ 14; transitions in the cycle after the crossing push or pop.
- At count=7, assert flush_in together with push and ack -> next cycle count_out=0, is_empty_out=1, request_valid_out=0, no overflow; the next push's data is read first.
- Assert reset_in asynchronously mid-burst at count=9 -> all outputs at reset values immediately; normal operation resumes after deassert.

Source files
------------

// File: rtl/threshold_fifo_queue.sv
// Parametrised synchronous FIFO with occupancy count, programmable almost-full/almost-empty
// flags, synchronous flush and a registered overflow pulse; any DEPTH >= 2.
module threshold_fifo_queue #(
    parameter int DATA_WIDTH             = 64,
    parameter int DEPTH                  = 16,
    parameter int PTR_WIDTH              = $clog2(DEPTH),
    parameter int COUNT_WIDTH            = $clog2(DEPTH + 1),
    parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 2,
    parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   flush_in,
    input  logic [DATA_WIDTH-1:0]  request_in,
    input  logic                   request_valid_in,
    output logic                   request_ready_out,
    output logic [DATA_WIDTH-1:0]  request_out,
    output logic                   request_valid_out,
    input  logic                   issue_ack_in,
    output logic [COUNT_WIDTH-1:0] count_out,
    output logic                   is_empty_out,
    output logic                   is_full_out,
    output logic                   almost_full_out,
    output logic                   almost_empty_out,
    output logic                   overflow_out
);

    localparam logic [PTR_WIDTH-1:0]   LAST_PTR  = PTR_WIDTH'(DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] FULL_CNT  = COUNT_WIDTH'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] AF_CNT    = COUNT_WIDTH'(ALMOST_FULL_THRESHOLD);
    localparam logic [COUNT_WIDTH-1:0] AE_CNT    = COUNT_WIDTH'(ALMOST_EMPTY_THRESHOLD);

    logic [DATA_WIDTH-1:0]  mem_r [DEPTH];
    logic [PTR_WIDTH-1:0]   rd_ptr_r;
    logic [PTR_WIDTH-1:0]   wr_ptr_r;
    logic [COUNT_WIDTH-1:0] count_next_s;
    logic                   push_s;
    logic                   pop_s;

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
        logic [PTR_WIDTH-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = {PTR_WIDTH{1'b0}};
        end else begin
            nxt = ptr + PTR_WIDTH'(1);
        end
        return nxt;
    endfunction

    assign push_s = request_valid_in & request_ready_out & ~flush_in;
    assign pop_s  = issue_ack_in & request_valid_out & ~flush_in;

    // Next occupancy; flush overrides any concurrent push or pop.
    always_comb begin
        count_next_s = count_out;
        if (flush_in) begin
            count_next_s = {COUNT_WIDTH{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_out + COUNT_WIDTH'(1);
                2'b01:   count_next_s = count_out - COUNT_WIDTH'(1);
                default: count_next_s = count_out;
            endcase
        end
    end

    // Pointers, occupancy and all status outputs, registered from count_next.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            rd_ptr_r          <= {PTR_WIDTH{1'b0}};
            wr_ptr_r          <= {PTR_WIDTH{1'b0}};
            count_out         <= {COUNT_WIDTH{1'b0}};
            is_empty_out      <= 1'b1;
            is_full_out       <= 1'b0;
            almost_full_out   <= 1'b0;
            almost_empty_out  <= 1'b1;
            request_ready_out <= 1'b1;
            request_valid_out <= 1'b0;
            overflow_out      <= 1'b0;
        end else begin
            if (flush_in) begin
                rd_ptr_r <= {PTR_WIDTH{1'b0}};
                wr_ptr_r <= {PTR_WIDTH{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= ptr_inc(wr_ptr_r);
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= ptr_inc(rd_ptr_r);
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
            end
            count_out         <= count_next_s;
            is_empty_out      <= (count_next_s == {COUNT_WIDTH{1'b0}});
            is_full_out       <= (count_next_s == FULL_CNT);
            almost_full_out   <= (count_next_s >= AF_CNT);
            almost_empty_out  <= (count_next_s <= AE_CNT);
            request_ready_out <= (count_next_s != FULL_CNT);
            request_valid_out <= (count_next_s != {COUNT_WIDTH{1'b0}});
            // A pop in the same cycle does not rescue a write against a full queue.
            overflow_out      <= request_valid_in & is_full_out & ~flush_in;
        end
    end

    // Entry storage; deliberately not reset, occupancy is tracked by the counter.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= request_in;
        end
    end

    assign request_out = request_valid_out ? mem_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_threshold_fifo_queue.sv
// Directed bench for threshold_fifo_queue: a DEPTH=16 instance and a DEPTH=5 instance
// sharing clock and reset, checked with immediate assertions against hand-computed values.
module tb_threshold_fifo_queue;

    logic        clk_in = 1'b0;
    logic        reset_in;

    logic        flush_a, valid_a, ack_a;
    logic [63:0] req_a;
    logic        ready_a, vout_a, empty_a, full_a, af_a, ae_a, ovf_a;
    logic [63:0] out_a;
    logic [4:0]  cnt_a;

    logic        flush_b, valid_b, ack_b;
    logic [63:0] req_b;
    logic        ready_b, vout_b, empty_b, full_b, af_b, ae_b, ovf_b;
    logic [63:0] out_b;
    logic [2:0]  cnt_b;

    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    threshold_fifo_queue #(.DATA_WIDTH(64), .DEPTH(16)) dut_a (
        .clk_in(clk_in), .reset_in(reset_in), .flush_in(flush_a),
        .request_in(req_a), .request_valid_in(valid_a), .request_ready_out(ready_a),
        .request_out(out_a), .request_valid_out(vout_a), .issue_ack_in(ack_a),
        .count_out(cnt_a), .is_empty_out(empty_a), .is_full_out(full_a),
        .almost_full_out(af_a), .almost_empty_out(ae_a), .overflow_out(ovf_a)
    );

    threshold_fifo_queue #(.DATA_WIDTH(64), .DEPTH(5)) dut_b (
        .clk_in(clk_in), .reset_in(reset_in), .flush_in(flush_b),
        .request_in(req_b), .request_valid_in(valid_b), .request_ready_out(ready_b),
        .request_out(out_b), .request_valid_out(vout_b), .issue_ack_in(ack_b),
        .count_out(cnt_b), .is_empty_out(empty_b), .is_full_out(full_b),
        .almost_full_out(af_b), .almost_empty_out(ae_b), .overflow_out(ovf_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        reset_in = 1'b1;
        flush_a = 1'b0; valid_a = 1'b0; ack_a = 1'b0; req_a = 64'h0;
        flush_b = 1'b0; valid_b = 1'b0; ack_b = 1'b0; req_b = 64'h0;
        #12;
        check("rst_count", 64'(cnt_a), 64'd0);
        check("rst_empty", 64'(empty_a), 64'd1);
        check("rst_ae", 64'(ae_a), 64'd1);
        check("rst_ready", 64'(ready_a), 64'd1);
        check("rst_full", 64'(full_a), 64'd0);
        check("rst_af", 64'(af_a), 64'd0);
        check("rst_valid", 64'(vout_a), 64'd0);
        check("rst_ovf", 64'(ovf_a), 64'd0);
        check("rst_data", out_a, 64'h0);
        reset_in = 1'b0;

        // In-order burst of six, valid lagging the first push by one cycle.
        valid_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_a = 64'h11 + 64'(i);
            if (i == 0) check("burst_valid_lag", 64'(vout_a), 64'd0);
            tick();
            check("burst_cnt_up", 64'(cnt_a), 64'(i + 1));
            check("burst_head", out_a, 64'h11);
        end
        valid_a = 1'b0;
        ack_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("burst_order", out_a, 64'h11 + 64'(i));
            tick();
            check("burst_cnt_down", 64'(cnt_a), 64'(5 - i));
        end
        ack_a = 1'b0;
        check("burst_drained_valid", 64'(vout_a), 64'd0);
        check("burst_drained_data", out_a, 64'h0);
        check("burst_drained_empty", 64'(empty_a), 64'd1);

        // Threshold sweep 0 -> 16 -> 0 with AF=14, AE=2.
        valid_a = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            req_a = 64'(k);
            tick();
            check("sweep_up_cnt", 64'(cnt_a), 64'(k));
            check("sweep_up_af", 64'(af_a), 64'(k >= 14));
            check("sweep_up_ae", 64'(ae_a), 64'(k <= 2));
        end
        check("sweep_full", 64'(full_a), 64'd1);
        check("sweep_ready", 64'(ready_a), 64'd0);
        valid_a = 1'b0;
        ack_a = 1'b1;
        for (int k = 15; k >= 0; k--) begin
            tick();
            check("sweep_dn_cnt", 64'(cnt_a), 64'(k));
            check("sweep_dn_af", 64'(af_a), 64'(k >= 14));
            check("sweep_dn_ae", 64'(ae_a), 64'(k <= 2));
        end
        ack_a = 1'b0;
        check("sweep_end_empty", 64'(empty_a), 64'd1);

        // Flush at count 7 together with push and ack.
        valid_a = 1'b1;
        for (int i = 0; i < 7; i++) begin
            req_a = 64'h40 + 64'(i);
            tick();
        end
        check("pre_flush_cnt", 64'(cnt_a), 64'd7);
        flush_a = 1'b1; ack_a = 1'b1; req_a = 64'hEE;
        tick();
        flush_a = 1'b0; ack_a = 1'b0;
        check("flush_cnt", 64'(cnt_a), 64'd0);
        check("flush_empty", 64'(empty_a), 64'd1);
        check("flush_valid", 64'(vout_a), 64'd0);
        check("flush_ovf", 64'(ovf_a), 64'd0);
        req_a = 64'hAA;
        tick();
        valid_a = 1'b0;
        check("post_flush_data", out_a, 64'hAA);
        check("post_flush_cnt", 64'(cnt_a), 64'd1);
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        check("post_flush_drain", 64'(cnt_a), 64'd0);

        // DEPTH=5: fill, overflow, full-with-pop refusal, drain across wrap.
        valid_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_b = 64'h21 + 64'(i);
            tick();
        end
        check("d5_full", 64'(full_b), 64'd1);
        check("d5_ready", 64'(ready_b), 64'd0);
        check("d5_cnt", 64'(cnt_b), 64'd5);
        req_b = 64'h99;
        tick();
        check("d5_ovf_pulse", 64'(ovf_b), 64'd1);
        check("d5_ovf_cnt", 64'(cnt_b), 64'd5);
        req_b = 64'h77; ack_b = 1'b1;
        tick();
        valid_b = 1'b0;
        check("d5_nobypass_cnt", 64'(cnt_b), 64'd4);
        check("d5_nobypass_ovf", 64'(ovf_b), 64'd1);
        check("d5_ready_back", 64'(ready_b), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("d5_drain_order", out_b, 64'h22 + 64'(i));
            tick();
            if (i == 0) check("d5_ovf_clear", 64'(ovf_b), 64'd0);
        end
        ack_b = 1'b0;
        check("d5_drained", 64'(cnt_b), 64'd0);

        // Sustained push+pop at count 3 across several wraps.
        valid_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_b = 64'h30 + 64'(i);
            tick();
        end
        ack_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req_b = 64'h33 + 64'(i);
            check("steady_order", out_b, 64'h30 + 64'(i));
            tick();
            check("steady_cnt", 64'(cnt_b), 64'd3);
        end
        valid_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("steady_tail", out_b, 64'h44 + 64'(i));
            tick();
        end
        ack_b = 1'b0;
        check("steady_empty", 64'(empty_b), 64'd1);

        // Asynchronous reset mid-burst at count 9.
        valid_a = 1'b1;
        for (int i = 0; i < 9; i++) begin
            req_a = 64'h60 + 64'(i);
            tick();
        end
        check("pre_rst_cnt", 64'(cnt_a), 64'd9);
        #3 reset_in = 1'b1;
        #1;
        check("arst_cnt", 64'(cnt_a), 64'd0);
        check("arst_valid", 64'(vout_a), 64'd0);
        check("arst_data", out_a, 64'h0);
        check("arst_empty", 64'(empty_a), 64'd1);
        check("arst_ready", 64'(ready_a), 64'd1);
        check("arst_af", 64'(af_a), 64'd0);
        req_a = 64'h55;
        #1 reset_in = 1'b0;
        tick();
        valid_a = 1'b0;
        check("post_rst_data", out_a, 64'h55);
        check("post_rst_cnt", 64'(cnt_a), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
